// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle linking the fetch and load/store requesters and the
// shared memory macro port to the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [BE_W-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic [BE_W-1:0]   m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side: answers both requesters and drives the memory port.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  // Environment side: requesters plus the memory macro.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with data priority and a bounded-wait guard that lets fetch through.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LAT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              win_fetch;
  logic              win_read;
  logic              fetch_win_c;
  logic              data_win_c;

  // Data wins by default; fetch wins when alone or after MAX_WAIT losses.
  always_comb begin
    fetch_win_c = 1'b0;
    data_win_c  = 1'b0;
    if (bus.i_req && (!bus.d_req || (wait_cnt >= WAIT_W'(MAX_WAIT)))) begin
      fetch_win_c = 1'b1;
    end else if (bus.d_req) begin
      data_win_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
      win_fetch    <= 1'b0;
      win_read     <= 1'b0;
      busy         <= 1'b0;
      bus.i_gnt    <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.i_rdata  <= DATA_W'(0);
      bus.d_gnt    <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= DATA_W'(0);
      bus.m_en     <= 1'b0;
      bus.m_we     <= BE_W'(0);
      bus.m_addr   <= ADDR_W'(0);
      bus.m_wdata  <= DATA_W'(0);
    end else begin
      bus.i_gnt    <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Count only the losses fetch actually suffers while requesting.
          if (!bus.i_req || fetch_win_c) begin
            wait_cnt <= '0;
          end else if (data_win_c && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
          if (fetch_win_c) begin
            win_fetch  <= 1'b1;
            win_read   <= 1'b1;
            bus.m_addr <= bus.i_addr;
            bus.m_we   <= BE_W'(0);
            bus.i_gnt  <= 1'b1;
            bus.m_en   <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end else if (data_win_c) begin
            win_fetch   <= 1'b0;
            win_read    <= (bus.d_we == BE_W'(0));
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
            bus.m_we    <= bus.d_we;
            bus.d_gnt   <= 1'b1;
            bus.m_en    <= 1'b1;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          bus.m_en <= 1'b0;
          bus.m_we <= BE_W'(0);
          lat_cnt  <= LAT_W'(RD_LAT);
          if (win_read) begin
            state <= RDWAIT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RDWAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          // Counter hits zero on this edge: memory data is valid now.
          if (lat_cnt == LAT_W'(1)) begin
            if (win_fetch) begin
              bus.i_rdata  <= bus.m_rdata;
              bus.i_rvalid <= 1'b1;
            end else begin
              bus.d_rdata  <= bus.m_rdata;
              bus.d_rvalid <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          bus.m_en <= 1'b0;
          bus.m_we <= BE_W'(0);
        end
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester.
- Serialises accesses, applies data-over-fetch priority with a starvation guard for fetch, and returns read data to the winning requester.
- Sits between the fetch/decode path and the load/store path on one side and the shared memory macro on the other.
- Allows a single combined memory to replace separate instruction and data memories.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- RD_LAT, 1, memory read latency in cycles from the m_en cycle to valid m_rdata. Legal range 1..4.
- MAX_WAIT, 3, number of consecutive arbitration losses after which fetch wins. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  one-cycle pulse: fetch issued to memory this cycle.
- i_rvalid  out  1  one-cycle pulse: i_rdata holds the fetched word.
- i_rdata  out  DATA_W  fetch data; holds its last value between reads.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt.
- d_we  in  DATA_W/8  byte write enables; 0 means read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data access issued this cycle.
- d_rvalid  out  1  one-cycle pulse: d_rdata holds the load word (reads only).
- d_rdata  out  DATA_W  load data; holds its last value between reads.
- m_en  out  1  memory access strobe.
- m_we  out  DATA_W/8  memory byte write enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the m_en cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, wait counter=0.
  - All outputs 0, including i_rdata/d_rdata.
  - An in-flight read is dropped: no rvalid is issued after reset.
  - rst has priority over every other event.
- States: IDLE, ACCESS, RDWAIT.
- IDLE:
  - Sample i_req/d_req and choose a winner.
  - d_req wins, unless i_req=1 and wait counter >= MAX_WAIT, in which case fetch wins.
  - The winner's request fields are registered. Next state is ACCESS; if neither request is high, stay in IDLE.
- Wait counter:
  - Increments (saturating at 15) each IDLE arbitration where i_req=1 and data wins.
  - Clears when fetch wins or when i_req=0 in IDLE.
- ACCESS (exactly 1 cycle):
  - m_en=1; m_addr, m_wdata, m_we driven from registered fields.
  - Winner's gnt pulses in this cycle.
  - m_we=d_we for a data write; m_we=0 for data reads and all fetches.
  - Write: next state IDLE, no rvalid.
  - Read: next state RDWAIT, with latency counter loaded to RD_LAT.
- RDWAIT:
  - Counter decrements each cycle.
  - When it reaches 0 (edge RD_LAT cycles after the ACCESS edge), m_rdata is captured into the winner's rdata register.
  - The winner's rvalid pulses for 1 cycle on the following cycle. Next state is IDLE.
- Timing:
  - Read: request seen in IDLE at cycle 0 → gnt at cycle 1 → rvalid at cycle 2+RD_LAT.
  - Write: occupies 2 cycles.
  - Outside ACCESS, m_en/m_we are 0; m_addr/m_wdata hold their values.
- Requester behaviour:
  - A request dropped before gnt is lost silently; requesters must not do this.
  - Requests arriving outside IDLE wait for the next IDLE.
  - Only one transaction is outstanding at a time; gnt and rvalid of the two ports are never high together.
- Simultaneous events:
  - i_req and d_req both high with counter < MAX_WAIT: data wins and the counter increments.
  - Data and fetch requests never merge.
- Width rules:
  - No address alignment checks and no data shifting; byte-lane steering is the requester's job.
- busy=0 only in IDLE.

Test Plan:
- Fetch only, RD_LAT=1: i_req=1, i_addr=0x10, m_rdata=0x00A00093 → i_gnt at cycle 1 with m_addr=0x10, m_we=0; i_rvalid at cycle 3 with i_rdata=0x00A00093.
- Data write: d_req=1, d_we=4'b0011, d_addr=0x1004, d_wdata=0xDEADBEEF → d_gnt with m_en=1, m_we=4'b0011, m_addr=0x1004, m_wdata=0xDEADBEEF; no d_rvalid; busy low 2 cycles after request.
- Contention: i_req and d_req held high continuously, MAX_WAIT=3 → grant order D,D,D,I,D,D,D,I; i_gnt never high with d_gnt.
- Latency sweep RD_LAT=1..4 on a data read of 0x00000055 → d_rvalid exactly 2+RD_LAT cycles after request; d_rdata=0x55 and held thereafter.
- Reset mid-read: assert rst in RDWAIT → next cycle all outputs 0, state IDLE, no i_rvalid/d_rvalid afterwards; the next request is served normally.
- Idle stability: both requests low for 20 cycles → m_en=0, busy=0, no gnt/rvalid pulses.
